// File: rtl/prime_cmd_mux.sv
// Forwards the PRIME string's actuator commands; forces SAFE_VALUE while blanking a switchover or when the prime string goes stale.
// Latency: prime -> prime_q 1 cycle, state reacts the cycle after; an accepted command reaches out_data 1 cycle after acceptance.
// Backpressure: none; both readys stay high and non-prime or blanked commands are discarded.
module prime_cmd_mux #(
    parameter int                DATA_W        = 8,
    parameter int                BLANK_CYCLES  = 25000,
    parameter int                STALE_TIMEOUT = 2500000,
    parameter logic [DATA_W-1:0] SAFE_VALUE    = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        prime,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic              cmd_a_valid,
    output logic              cmd_a_ready,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_b_valid,
    output logic              cmd_b_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_strobe,
    output logic [1:0]        active_str,
    output logic              stale,
    output logic [7:0]        switch_cnt
);

    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam int SW = $clog2(STALE_TIMEOUT + 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [SW-1:0] STALE_LAST = SW'(STALE_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_PASS_A, S_PASS_B, S_BLANK} state_t;

    state_t            state_q, state_d;
    logic [1:0]        prime_q, prime_d;
    logic              tgt_b_q, tgt_b_d;
    logic [BW-1:0]     blank_cnt_q, blank_cnt_d;
    logic [SW-1:0]     stale_cnt_q, stale_cnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_strobe_q, out_strobe_d;
    logic [1:0]        active_str_q, active_str_d;
    logic              stale_q, stale_d;
    logic [7:0]        switch_cnt_q, switch_cnt_d;

    logic prime_a, prime_b, acc_a, acc_b, enter_blank;

    always_comb begin
        prime_a     = (prime_q == 2'b01);
        prime_b     = (prime_q == 2'b10);
        acc_a       = (state_q == S_PASS_A) && cmd_a_valid;
        acc_b       = (state_q == S_PASS_B) && cmd_b_valid;
        prime_d     = prime;
        state_d     = state_q;
        tgt_b_d     = tgt_b_q;
        blank_cnt_d = '0;
        enter_blank = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (prime_a || prime_b) begin
                    state_d     = S_BLANK;
                    tgt_b_d     = prime_b;
                    enter_blank = 1'b1;
                end
            end
            S_PASS_A: begin
                if (prime_b) begin
                    state_d     = S_BLANK;
                    tgt_b_d     = 1'b1;
                    enter_blank = 1'b1;
                end else if (!prime_a) begin
                    state_d = S_IDLE;
                end
            end
            S_PASS_B: begin
                if (prime_a) begin
                    state_d     = S_BLANK;
                    tgt_b_d     = 1'b0;
                    enter_blank = 1'b1;
                end else if (!prime_b) begin
                    state_d = S_IDLE;
                end
            end
            S_BLANK: begin
                // A flip to the other string restarts the whole interval.
                if (!prime_a && !prime_b) begin
                    state_d = S_IDLE;
                end else if (prime_b != tgt_b_q) begin
                    tgt_b_d     = prime_b;
                    enter_blank = 1'b1;
                end else if (blank_cnt_q == BLANK_LAST) begin
                    state_d = tgt_b_q ? S_PASS_B : S_PASS_A;
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        switch_cnt_d = switch_cnt_q;
        if (enter_blank && switch_cnt_q != 8'hFF) begin
            switch_cnt_d = switch_cnt_q + 8'd1;
        end

        out_data_d   = out_data_q;
        out_strobe_d = 1'b0;
        stale_d      = stale_q;
        stale_cnt_d  = stale_cnt_q;
        if (state_d == S_IDLE || state_d == S_BLANK) begin
            out_data_d  = SAFE_VALUE;
            stale_d     = 1'b0;
            stale_cnt_d = '0;
        end else if (state_d == state_q) begin
            // Acceptance is checked first so it beats a coincident timeout.
            if (acc_a || acc_b) begin
                out_data_d   = acc_a ? cmd_a : cmd_b;
                out_strobe_d = 1'b1;
                stale_d      = 1'b0;
                stale_cnt_d  = '0;
            end else if (stale_cnt_q == STALE_LAST) begin
                stale_d    = 1'b1;
                out_data_d = SAFE_VALUE;
            end else begin
                stale_cnt_d = stale_cnt_q + 1'b1;
            end
        end

        active_str_d = (state_d == S_PASS_A) ? 2'b01 :
                       (state_d == S_PASS_B) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prime_q      <= 2'b00;
            state_q      <= S_IDLE;
            tgt_b_q      <= 1'b0;
            blank_cnt_q  <= '0;
            stale_cnt_q  <= '0;
            out_data_q   <= SAFE_VALUE;
            out_strobe_q <= 1'b0;
            active_str_q <= 2'b00;
            stale_q      <= 1'b0;
            switch_cnt_q <= 8'd0;
        end else begin
            prime_q      <= prime_d;
            state_q      <= state_d;
            tgt_b_q      <= tgt_b_d;
            blank_cnt_q  <= blank_cnt_d;
            stale_cnt_q  <= stale_cnt_d;
            out_data_q   <= out_data_d;
            out_strobe_q <= out_strobe_d;
            active_str_q <= active_str_d;
            stale_q      <= stale_d;
            switch_cnt_q <= switch_cnt_d;
        end
    end

    // Every state either passes a string through or discards it, so neither side ever stalls.
    assign cmd_a_ready = 1'b1;
    assign cmd_b_ready = 1'b1;
    assign out_data    = out_data_q;
    assign out_strobe  = out_strobe_q;
    assign active_str  = active_str_q;
    assign stale       = stale_q;
    assign switch_cnt  = switch_cnt_q;

endmodule
